// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: memory request/response port, redirect input and decode-side instruction handshake.
// The fetch unit takes the master view; memory, branch unit and decode together take the slave view.
interface fetch_unit_if;
    logic        fetch_en;
    logic [31:0] mem_address;
    logic [1:0]  mem_access_size;
    logic        mem_rw;
    logic        mem_enable;
    logic [31:0] mem_data_in;
    logic        mem_busy;
    logic [31:0] mem_data_out;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        insn_valid;
    logic [31:0] insn;
    logic [31:0] insn_pc;
    logic        insn_ready;

    modport master (
        input  fetch_en, mem_busy, mem_data_out, redirect, redirect_pc, insn_ready,
        output mem_address, mem_access_size, mem_rw, mem_enable, mem_data_in,
               insn_valid, insn, insn_pc
    );

    modport slave (
        output fetch_en, mem_busy, mem_data_out, redirect, redirect_pc, insn_ready,
        input  mem_address, mem_access_size, mem_rw, mem_enable, mem_data_in,
               insn_valid, insn, insn_pc
    );
endinterface

// File: rtl/fetch_unit.sv
// sync_fifo: generic single-clock FIFO with synchronous flush; head data reads as zero when empty.
// Latency: a pushed entry is visible at the head one cycle after the push edge.
// Backpressure: pushes into a full FIFO and pops from an empty one are ignored; flush beats both.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic                   push_vld,
    input  logic [WIDTH-1:0]       push_dat,
    input  logic                   pop_rdy,
    output logic                   pop_vld,
    output logic [WIDTH-1:0]       pop_dat,
    output logic [$clog2(DEPTH):0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign pop_vld = (count != '0);
    assign pop_dat = pop_vld ? mem[rd_ptr] : '0;
    assign do_push = push_vld && !flush && (count != CW'(DEPTH));
    assign do_pop  = pop_rdy && pop_vld && !flush;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the head is masked while count is zero.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// fetch_unit: issues single-word reads at the PC and queues {word, pc} for decode.
// Latency: one request in flight; a word reaches the queue RD_LATENCY edges after acceptance.
// Backpressure: holds the request while mem_busy; stops issuing while the queue is full.
module fetch_unit #(
    parameter logic [31:0] START_ADDR = 32'h8002_0000,
    parameter int          RD_LATENCY = 1,
    parameter int          DEPTH      = 2
) (
    input  logic          clock,
    input  logic          reset_n,
    fetch_unit_if.master  bus
);
    localparam int LW   = $clog2(RD_LATENCY + 1);
    localparam int CNTW = $clog2(DEPTH) + 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [31:0]       pc;
    logic [LW-1:0]     lat_cnt;
    logic              drop;
    logic [CNTW-1:0]   fifo_count;
    logic [CNTW-1:0]   post_count;
    logic              accept;
    logic              resp;
    logic              push;
    logic              pop;
    logic [63:0]       head_dat;

    assign accept = (state == S_REQ) && !bus.mem_busy && !bus.redirect;
    assign resp   = (state == S_WAIT) && (lat_cnt == LW'(1));
    assign push   = resp && !drop && !bus.redirect;
    assign pop    = bus.insn_valid && bus.insn_ready;

    // Occupancy as it will be after this edge; a redirect empties the queue.
    assign post_count = bus.redirect ? '0
                      : fifo_count + CNTW'(push) - CNTW'(pop);

    sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_fifo (
        .clock    (clock),
        .reset_n  (reset_n),
        .flush    (bus.redirect),
        .push_vld (push),
        .push_dat ({bus.mem_data_out, pc}),
        .pop_rdy  (bus.insn_ready),
        .pop_vld  (bus.insn_valid),
        .pop_dat  (head_dat),
        .count    (fifo_count)
    );

    assign bus.insn            = head_dat[63:32];
    assign bus.insn_pc         = head_dat[31:0];
    assign bus.mem_enable      = (state == S_REQ);
    assign bus.mem_address     = pc;
    assign bus.mem_access_size = 2'b00;
    assign bus.mem_rw          = 1'b0;
    assign bus.mem_data_in     = 32'h0;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE: begin
                if (bus.fetch_en && (fifo_count < CNTW'(DEPTH))) state_nxt = S_REQ;
            end
            S_REQ: begin
                if (bus.redirect)      state_nxt = bus.fetch_en ? S_REQ : S_IDLE;
                else if (!bus.mem_busy) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (resp) state_nxt = (bus.fetch_en && (post_count < CNTW'(DEPTH))) ? S_REQ : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            pc      <= START_ADDR;
            lat_cnt <= '0;
            drop    <= 1'b0;
        end else begin
            state <= state_nxt;

            if (bus.redirect)  pc <= bus.redirect_pc & 32'hFFFF_FFFC;
            else if (push)     pc <= pc + 32'd4;

            if (accept)                lat_cnt <= LW'(RD_LATENCY);
            else if (state == S_WAIT)  lat_cnt <= lat_cnt - LW'(1);

            // A redirect that coincides with the response already discards it.
            if (resp)                                drop <= 1'b0;
            else if ((state == S_WAIT) && bus.redirect) drop <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-2 memory responder, a queue-level model checked every cycle,
// and hand-computed expectations for reset, ordering, fill, busy hold, redirects and mid-request reset.
module tb_fetch_unit;
    localparam logic [31:0] START = 32'h8002_0000;
    localparam int          LAT   = 2;
    localparam int          DEP   = 2;

    typedef struct packed {
        logic [31:0] w;
        logic [31:0] pc;
    } ent_t;

    logic clock;
    logic reset_n;
    fetch_unit_if bus();

    fetch_unit #(.START_ADDR(START), .RD_LATENCY(LAT), .DEPTH(DEP)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_on   = 0;

    initial begin
        clock = 0;
        forever #5 clock = ~clock;
    end

    function automatic logic [31:0] memword(input logic [31:0] a);
        case (a)
            32'h8002_0000: return 32'h1111_1111;
            32'h8002_0004: return 32'h2222_2222;
            32'h8002_0008: return 32'h3333_3333;
            default:       return a ^ 32'h5A5A_0000;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Memory: single-outstanding responder; data is garbage until the response is due.
    int          n_acc = 0;
    logic [31:0] acc_addr = '0;
    initial begin
        logic [31:0] a;
        bus.mem_data_out = 32'h0;
        forever begin
            @(posedge clock);
            if (reset_n && bus.mem_enable && !bus.mem_busy) begin
                n_acc++;
                a        = bus.mem_address;
                acc_addr = a;
                #1 bus.mem_data_out = 32'hDEAD_BEEF;
                for (int i = 1; i < LAT; i++) begin
                    @(posedge clock);
                    chk("one_outstanding", 32'(bus.mem_enable && !bus.mem_busy), 32'h0);
                    #1;
                end
                bus.mem_data_out = memword(a);
            end
        end
    end

    // Queue-level model: a presented request, an outstanding countdown and a discard flag.
    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    bit          m_req, m_disc, b_pop, b_acc, b_arr, n_req;
    int          m_out, sz0;

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_pc   = START;
            m_addr = '0;
            m_req  = 0;
            m_out  = 0;
            m_disc = 0;
        end else begin
            sz0   = m_q.size();
            b_pop = (sz0 > 0) && bus.insn_ready;
            b_acc = m_req && !bus.mem_busy && !bus.redirect;
            b_arr = (m_out == 1);
            if (bus.redirect) m_q.delete();
            else begin
                if (b_pop) m_q.delete(0);
                if (b_arr && !m_disc) m_q.push_back('{memword(m_addr), m_pc});
            end
            if (m_req)        n_req = bus.redirect ? bus.fetch_en : bus.mem_busy;
            else if (m_out > 0) n_req = b_arr && bus.fetch_en && (m_q.size() < DEP);
            else              n_req = bus.fetch_en && (sz0 < DEP);
            if (b_acc) begin
                m_addr = m_pc;
                m_out  = LAT;
            end else if (m_out > 0) m_out--;
            if (bus.redirect)            m_pc = bus.redirect_pc & 32'hFFFF_FFFC;
            else if (b_arr && !m_disc)   m_pc = m_pc + 32'd4;
            if (b_arr)                           m_disc = 0;
            else if (bus.redirect && m_out > 0)  m_disc = 1;
            m_req = n_req;
        end
    end

    ent_t log_q[$];
    always @(negedge clock) begin
        if (cmp_on) begin
            chk("mem_enable", 32'(bus.mem_enable), 32'(m_req));
            chk("mem_address", bus.mem_address, m_pc);
            chk("insn_valid", 32'(bus.insn_valid), 32'(m_q.size() > 0));
            chk("insn", bus.insn, (m_q.size() > 0) ? m_q[0].w : 32'h0);
            chk("insn_pc", bus.insn_pc, (m_q.size() > 0) ? m_q[0].pc : 32'h0);
            chk("const_outs", {bus.mem_data_in[29:0], bus.mem_access_size}, {29'h0, bus.mem_rw, 2'b00});
            if (bus.insn_valid && bus.insn_ready) log_q.push_back('{bus.insn, bus.insn_pc});
        end
    end

    task automatic wait_req();
        for (int k = 0; k < 60; k++) begin
            if (bus.mem_enable) return;
            step(1);
        end
        timeout("wait_req");
    endtask

    task automatic wait_log(input int n);
        for (int k = 0; k < 80; k++) begin
            if (log_q.size() >= n) return;
            step(1);
        end
        timeout("wait_log");
    endtask

    initial begin
        logic [31:0] a0, stale;
        int n0, L;
        reset_n = 1;
        bus.fetch_en = 1; bus.mem_busy = 0; bus.redirect = 0;
        bus.redirect_pc = 0; bus.insn_ready = 0;
        #1 reset_n = 0;
        #1 cmp_on = 1;
        chk("rst_enable", 32'(bus.mem_enable), 32'h0);
        chk("rst_address", bus.mem_address, 32'h8002_0000);
        chk("rst_valid", 32'(bus.insn_valid), 32'h0);
        chk("rst_insn", bus.insn, 32'h0);
        chk("rst_insn_pc", bus.insn_pc, 32'h0);
        step(2);
        reset_n = 1;
        chk("first_cycle_idle", 32'(bus.mem_enable), 32'h0);
        step(1);
        chk("first_req_en", 32'(bus.mem_enable), 32'h1);
        chk("first_req_addr", bus.mem_address, 32'h8002_0000);

        // Fill with decode stalled: exactly two requests, then quiet.
        step(20);
        chk("fill_accepts", 32'(n_acc), 32'd2);
        chk("fill_idle", 32'(bus.mem_enable), 32'h0);
        chk("fill_head", bus.insn, 32'h1111_1111);
        chk("fill_head_pc", bus.insn_pc, 32'h8002_0000);
        bus.insn_ready = 1;
        wait_req();
        chk("third_req_addr", bus.mem_address, 32'h8002_0008);
        wait_log(3);
        if (log_q.size() >= 3) begin
            chk("order0_w", log_q[0].w, 32'h1111_1111);
            chk("order0_pc", log_q[0].pc, 32'h8002_0000);
            chk("order1_w", log_q[1].w, 32'h2222_2222);
            chk("order1_pc", log_q[1].pc, 32'h8002_0004);
            chk("order2_w", log_q[2].w, 32'h3333_3333);
            chk("order2_pc", log_q[2].pc, 32'h8002_0008);
        end

        // Busy hold for three cycles, then exactly one acceptance.
        wait_req();
        bus.mem_busy = 1;
        a0 = bus.mem_address;
        n0 = n_acc;
        for (int k = 0; k < 3; k++) begin
            step(1);
            chk("busy_hold_en", 32'(bus.mem_enable), 32'h1);
            chk("busy_hold_addr", bus.mem_address, a0);
        end
        bus.mem_busy = 0;
        step(1);
        chk("busy_one_accept", 32'(n_acc), 32'(n0 + 1));
        chk("busy_then_wait", 32'(bus.mem_enable), 32'h0);

        // Redirect while the response is still two edges away: it must be dropped.
        stale = memword(acc_addr);
        bus.redirect = 1; bus.redirect_pc = 32'h8002_0103;
        step(1);
        bus.redirect = 0;
        L = log_q.size();
        chk("redir_valid_low", 32'(bus.insn_valid), 32'h0);
        wait_req();
        chk("redir_req_addr", bus.mem_address, 32'h8002_0100);
        wait_log(L + 1);
        if (log_q.size() > L) begin
            chk("redir_first_pc", log_q[L].pc, 32'h8002_0100);
            chk("redir_no_stale", 32'(log_q[L].w == stale), 32'h0);
        end

        // Redirect on the very edge the response returns.
        wait_req();
        step(2);
        bus.redirect = 1; bus.redirect_pc = 32'h8002_0200;
        step(1);
        bus.redirect = 0;
        wait_req();
        chk("sameedge_req_addr", bus.mem_address, 32'h8002_0200);

        // Redirect coinciding with a pop while the queue is full.
        bus.insn_ready = 0;
        for (int k = 0; k < 60 && !(m_q.size() == DEP && !m_req && m_out == 0); k++) step(1);
        chk("full_before_flush", 32'(bus.insn_valid), 32'h1);
        bus.insn_ready = 1; bus.redirect = 1; bus.redirect_pc = 32'h8002_0300;
        step(1);
        bus.redirect = 0; bus.insn_ready = 0;
        chk("flush_valid", 32'(bus.insn_valid), 32'h0);
        chk("flush_insn", bus.insn, 32'h0);
        for (int k = 0; k < 60 && !bus.insn_valid; k++) step(1);
        chk("flush_refill_pc", bus.insn_pc, 32'h8002_0300);
        chk("flush_refill_w", bus.insn, memword(32'h8002_0300));

        // Reset in the middle of an outstanding read.
        bus.insn_ready = 1;
        wait_req();
        step(1);
        reset_n = 0;
        #1;
        chk("midrst_enable", 32'(bus.mem_enable), 32'h0);
        chk("midrst_address", bus.mem_address, 32'h8002_0000);
        chk("midrst_valid", 32'(bus.insn_valid), 32'h0);
        chk("midrst_insn", bus.insn, 32'h0);
        chk("midrst_insn_pc", bus.insn_pc, 32'h0);
        step(3);
        reset_n = 1;
        step(30);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end
endmodule
